// File: rtl/vec_chunk_buffer_if.sv
// Sample-stream and chunk-read bundle for vec_chunk_buffer.
// master = producer/consumer side, slave = the buffer.
interface vec_chunk_buffer_if #(
  parameter int NBits       = 16,
  parameter int WorkingRegs = 4
);
  logic                                       in_valid;
  logic signed [NBits-1:0]                    in_sample;
  logic                                       in_ready;
  logic                                       out_data_ready;
  logic signed [WorkingRegs-1:0][NBits-1:0]   out_data;
  logic                                       req_chunk_in;
  logic                                       req_chunk_ptr_rst;
  logic                                       vec_done;

  modport master (
    output in_valid,
    output in_sample,
    output req_chunk_in,
    output req_chunk_ptr_rst,
    output vec_done,
    input  in_ready,
    input  out_data_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  req_chunk_in,
    input  req_chunk_ptr_rst,
    input  vec_done,
    output in_ready,
    output out_data_ready,
    output out_data
  );
endinterface

// File: rtl/vec_chunk_buffer.sv
// Ping-pong vector buffer: packs a serial sample stream into vectors
// and replays the read bank as WorkingRegs-wide chunks.
module vec_chunk_buffer #(
  parameter int InVecLength = 8,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  vec_chunk_buffer_if.slave  bus
);

  localparam int NChunks = InVecLength / WorkingRegs;
  localparam int IW = (InVecLength > 1) ? $clog2(InVecLength) : 1;
  localparam int CW = (NChunks > 1) ? $clog2(NChunks) : 1;

  typedef logic signed [NBits-1:0] samp_t;

  samp_t          mem_q [2][InVecLength];
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [IW-1:0]  wr_idx_q, wr_idx_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [1:0]     full_q, full_d;

  logic           wr_fire;
  logic           wr_last;
  logic           rd_rdy;
  logic           done_fire;

  logic signed [WorkingRegs-1:0][NBits-1:0] rd_chunk;

  always_comb begin
    rd_rdy    = full_q[rd_bank_q];
    wr_fire   = bus.in_valid & ~full_q[wr_bank_q];
    wr_last   = wr_fire & (wr_idx_q == IW'(InVecLength - 1));
    done_fire = bus.vec_done & rd_rdy;

    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    ptr_d     = ptr_q;
    full_d    = full_q;

    if (wr_fire) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + 1'b1;
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    // A last write and a release always hit different banks
    if (done_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      ptr_d             = '0;
    end else if (rd_rdy & bus.req_chunk_ptr_rst) begin
      ptr_d = '0;
    end else if (rd_rdy & bus.req_chunk_in) begin
      ptr_d = (ptr_q == CW'(NChunks - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      ptr_q     <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
    end
  end

  // Sample storage is left uninitialised by reset
  always_ff @(posedge clk_in) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= bus.in_sample;
    end
  end

  always_comb begin
    rd_chunk = '0;
    if (rd_rdy) begin
      for (int i = 0; i < WorkingRegs; i++) begin
        rd_chunk[i] = mem_q[rd_bank_q][IW'(int'(ptr_q) * WorkingRegs + i)];
      end
    end
  end

  assign bus.in_ready       = ~full_q[wr_bank_q];
  assign bus.out_data_ready = rd_rdy;
  assign bus.out_data       = rd_chunk;

endmodule

// File: doc/vec_chunk_buffer.md
Name: vec_chunk_buffer

Overview:
- Ping-pong input-vector buffer that feeds the matrix-vector multiply stage.
- Accepts a serial stream of NBits samples and packs them into complete InVecLength vectors.
- Presents each vector as WorkingRegs-wide chunks through a single-cycle chunk-FIFO interface: advance on req_chunk_in, rewind on req_chunk_ptr_rst.
- Holds a second bank, so the next vector loads while the current one is reread for every output row.

Parameters:
InVecLength, 8, elements per input vector; must be a multiple of WorkingRegs.
WorkingRegs, 4, elements per output chunk.
NBits, 16, signed sample width.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active-high
in_valid  input  1  in_sample is valid this cycle
in_sample  input  NBits  signed serial sample
in_ready  output  1  buffer can accept a sample this cycle
out_data_ready  output  1  a complete vector is available in the read bank
out_data  output  WorkingRegs*NBits  current chunk, packed signed [WorkingRegs-1:0][NBits-1:0]
req_chunk_in  input  1  consumer advances to the next chunk
req_chunk_ptr_rst  input  1  consumer rewinds to chunk 0 of the same vector
vec_done  input  1  single-cycle pulse: consumer has finished the read-bank vector, release it

Behaviour:
- Reset (async, rst_in=1):
  - wr_bank=0, rd_bank=0, wr_idx=0, chunk_ptr=0, both full flags=0.
  - Outputs: in_ready=1, out_data_ready=0, out_data=0.
  - Sample storage is not cleared.
  - Reset mid-vector discards partial and full vectors alike.
- Storage: two banks, each InVecLength x NBits. NChunks = InVecLength/WorkingRegs.
- Write side:
  - in_ready = ~full[wr_bank] (combinational from registers).
  - A transfer happens when in_valid & in_ready. The sample is stored at bank[wr_bank][wr_idx] and wr_idx increments.
  - When the transfer writes wr_idx==InVecLength-1: wr_idx<=0, full[wr_bank]<=1, wr_bank toggles.
  - in_valid while in_ready=0 is ignored; no sample is stored.
- Read side:
  - out_data_ready = full[rd_bank].
  - out_data[i] = bank[rd_bank][chunk_ptr*WorkingRegs + i] for i in 0..WorkingRegs-1. Element 0 is the first sample received.
  - out_data is forced to 0 while out_data_ready=0.
  - out_data is a combinational read of registered storage and pointer. A request in cycle t changes out_data in cycle t+1.
- Chunk pointer update, in priority order:
  1. vec_done, if full[rd_bank]: full[rd_bank]<=0, rd_bank toggles, chunk_ptr<=0.
  2. req_chunk_ptr_rst: chunk_ptr<=0.
  3. req_chunk_in: chunk_ptr<=chunk_ptr+1, wrapping from NChunks-1 to 0.
  4. Otherwise chunk_ptr holds.
- Request gating and edge cases:
  - req_chunk_in and req_chunk_ptr_rst are ignored while out_data_ready=0.
  - vec_done is ignored when full[rd_bank]=0.
- Simultaneous events:
  - A last-sample write and vec_done in the same cycle on different banks both take effect.
  - When both banks are full, in_ready=0. A vec_done then raises in_ready the next cycle, because wr_bank already points at the freed bank.
  - When the write of the final sample lands in the bank rd_bank selects, out_data_ready rises the following cycle.
- NChunks==1 (InVecLength==WorkingRegs): chunk_ptr stays 0; req_chunk_in has no effect.
- Throughput: one sample per cycle sustained, provided the consumer issues vec_done before the other bank fills.

Test Plan (InVecLength=8, WorkingRegs=4, NBits=8):
1. Fill: stream samples 1..8 one per cycle.
   - in_ready stays 1 throughout.
   - out_data_ready=1 on the cycle after sample 8.
   - out_data = {4,3,2,1} (element 0 in the low lane).
2. Chunk walk:
   - req_chunk_in pulse -> out_data={8,7,6,5} next cycle.
   - Second pulse -> wraps to {4,3,2,1}.
   - req_chunk_in together with req_chunk_ptr_rst -> {4,3,2,1}; rewind wins.
3. Ping-pong:
   - Stream 1..8 then 11..18 -> in_ready=0 after sample 18.
   - Drive in_valid with 99 while in_ready=0 -> not stored.
   - vec_done -> next cycle in_ready=1, out_data={14,13,12,11}, out_data_ready=1.
4. Concurrent:
   - Stream the second vector while the consumer reads the first.
   - Assert vec_done on the same cycle as sample 18's write.
   - Next cycle: rd_bank=1, out_data={14,13,12,11}, in_ready=1.
5. Reset mid-fill: after samples 1..5 assert rst_in asynchronously (between clock edges).
   - Immediately: out_data_ready=0, in_ready=1.
   - Then stream 21..28 -> out_data={24,23,22,21}.
6. Negative values: stream -1,-128,127,0,5,-5,2,-2.
   - Chunk 0 = {0,127,-128,-1}; sign bits preserved.
   - vec_done with no full bank -> no state change.
